// File: rtl/scalar_writeback_arbiter_if.sv
// Write-port arbitration bus: pipeline writeback, memory fill handshake and register-file write.
// master = pipeline/memory side, slave = arbiter.
interface scalar_writeback_arbiter_if;
    logic        wb_valid_i;
    logic [6:0]  wb_reg_i;
    logic [31:0] wb_value_i;
    logic        fill_valid_i;
    logic        fill_ready_o;
    logic [6:0]  fill_reg_i;
    logic [31:0] fill_value_i;
    logic        stall_o;
    logic        rf_write_enable_o;
    logic [6:0]  rf_write_reg_o;
    logic [31:0] rf_write_value_o;
    logic        protocol_err_o;

    modport master (
        output wb_valid_i, wb_reg_i, wb_value_i,
        output fill_valid_i, fill_reg_i, fill_value_i,
        input  fill_ready_o, stall_o, protocol_err_o,
        input  rf_write_enable_o, rf_write_reg_o, rf_write_value_o
    );

    modport slave (
        input  wb_valid_i, wb_reg_i, wb_value_i,
        input  fill_valid_i, fill_reg_i, fill_value_i,
        output fill_ready_o, stall_o, protocol_err_o,
        output rf_write_enable_o, rf_write_reg_o, rf_write_value_o
    );
endinterface

// File: rtl/scalar_writeback_arbiter.sv
// Shares the scalar register-file write port between pipeline writeback and buffered memory fills.
// Optional feature macro WB_ARB_FILL_BYPASS_EN: a fill into an idle, empty arbiter is written in the same cycle.
module scalar_writeback_arbiter #(
    parameter int unsigned FILL_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    scalar_writeback_arbiter_if.slave    bus
);
    localparam int unsigned REG_W    = 7;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PTR_W    = $clog2(FILL_FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [REG_W-1:0]           fifo_reg [FILL_FIFO_DEPTH];
    logic [DATA_W-1:0]          fifo_val [FILL_FIFO_DEPTH];
    logic [FILL_FIFO_DEPTH-1:0] fifo_live;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [STARVE_W-1:0]        starve_cnt;
    logic                       stall_q;
    logic                       fill_ready_q;
    logic                       err_q;

    logic                       empty_c;
    logic                       stall_grant_c;
    logic                       wb_grant_c;
    logic                       pop_c;
    logic                       accept_c;
    logic                       bypass_c;
    logic                       push_c;
    logic                       push_live_c;
    logic                       starve_hit_c;
    logic [CNT_W-1:0]           count_next_c;
    logic [FILL_FIFO_DEPTH-1:0] squash_c;
    logic [FILL_FIFO_DEPTH-1:0] live_next_c;
    logic                       rf_we_c;
    logic [REG_W-1:0]           rf_reg_c;
    logic [DATA_W-1:0]          rf_val_c;

    // Grant: a pending forced drain beats writeback, writeback beats an ordinary drain.
    assign empty_c       = (count == '0);
    assign stall_grant_c = stall_q & ~empty_c;
    assign wb_grant_c    = bus.wb_valid_i & ~stall_grant_c;
    assign pop_c         = stall_grant_c | (~bus.wb_valid_i & ~empty_c);
    assign accept_c      = bus.fill_valid_i & fill_ready_q;

`ifdef WB_ARB_FILL_BYPASS_EN
    assign bypass_c = accept_c & empty_c & ~bus.wb_valid_i & ~stall_q;
`else
    assign bypass_c = 1'b0;
`endif

    assign push_c       = accept_c & ~bypass_c;
    // A fill accepted alongside a writeback to the same register is older than that writeback.
    assign push_live_c  = ~(wb_grant_c && (bus.fill_reg_i == bus.wb_reg_i));
    assign count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    assign starve_hit_c = wb_grant_c & ~empty_c &
                          (starve_cnt == STARVE_W'(STARVE_LIMIT - 1));

    for (genvar g = 0; g < FILL_FIFO_DEPTH; g++) begin : g_squash
        assign squash_c[g] = wb_grant_c && (fifo_reg[g] == bus.wb_reg_i);
    end

    always_comb begin
        live_next_c = fifo_live & ~squash_c;
        if (push_c) begin
            live_next_c[wr_ptr] = push_live_c;
        end
    end

    // Register-file write mux; squashed heads drain with the write enable low.
    always_comb begin
        rf_we_c  = 1'b0;
        rf_reg_c = '0;
        rf_val_c = '0;
        if (!reset) begin
            if (pop_c) begin
                rf_we_c  = fifo_live[rd_ptr];
                rf_reg_c = fifo_reg[rd_ptr];
                rf_val_c = fifo_val[rd_ptr];
            end else if (wb_grant_c) begin
                rf_we_c  = 1'b1;
                rf_reg_c = bus.wb_reg_i;
                rf_val_c = bus.wb_value_i;
            end else if (bypass_c) begin
                rf_we_c  = 1'b1;
                rf_reg_c = bus.fill_reg_i;
                rf_val_c = bus.fill_value_i;
            end
        end
    end

    // Fill payload storage; validity is tracked separately in fifo_live.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_reg[wr_ptr] <= bus.fill_reg_i;
            fifo_val[wr_ptr] <= bus.fill_value_i;
        end
    end

    // Pointers, occupancy, starvation tracking and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_live    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            stall_q      <= 1'b0;
            fill_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            fifo_live    <= live_next_c;
            count        <= count_next_c;
            fill_ready_q <= (count_next_c != CNT_W'(FILL_FIFO_DEPTH));
            stall_q      <= starve_hit_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (empty_c || pop_c || starve_hit_c) begin
                starve_cnt <= '0;
            end else if (wb_grant_c) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            if (bus.wb_valid_i && stall_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.fill_ready_o      = fill_ready_q;
    assign bus.stall_o           = stall_q;
    assign bus.protocol_err_o    = err_q;
    assign bus.rf_write_enable_o = rf_we_c;
    assign bus.rf_write_reg_o    = rf_reg_c;
    assign bus.rf_write_value_o  = rf_val_c;
endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Directed bench for scalar_writeback_arbiter: expected register-file writes are queued by the
// stimulus and checked in order by an independent monitor.
module tb_scalar_writeback_arbiter;
    localparam bit BYP =
`ifdef WB_ARB_FILL_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic [6:0]  r;
        logic [31:0] v;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    wr_t  exp_q[$];
    logic [31:0] shadow [128];

    scalar_writeback_arbiter_if bus ();

    scalar_writeback_arbiter #(
        .FILL_FIFO_DEPTH(4),
        .STARVE_LIMIT   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic [6:0] wr, input logic [31:0] wd,
                         input logic fv, input logic [6:0] fr, input logic [31:0] fd);
        bus.wb_valid_i   = wv;
        bus.wb_reg_i     = wr;
        bus.wb_value_i   = wd;
        bus.fill_valid_i = fv;
        bus.fill_reg_i   = fr;
        bus.fill_value_i = fd;
    endtask

    task automatic expect_wr(input logic [6:0] r, input logic [31:0] v);
        wr_t e;
        e.r = r;
        e.v = v;
        exp_q.push_back(e);
    endtask

    // Monitor: every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.rf_write_enable_o) begin
            wr_t e;
            n_cmp++;
            shadow[bus.rf_write_reg_o] = bus.rf_write_value_o;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rf_write: unexpected write reg %h value %h at %0t",
                         bus.rf_write_reg_o, bus.rf_write_value_o, $time);
            end else begin
                e = exp_q.pop_front();
                if (bus.rf_write_reg_o !== e.r || bus.rf_write_value_o !== e.v) begin
                    n_err++;
                    $display("FAIL rf_write: got reg %h value %h expected reg %h value %h at %0t",
                             bus.rf_write_reg_o, bus.rf_write_value_o, e.r, e.v, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_fill_ready", 32'(bus.fill_ready_o), 32'd0);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_err", 32'(bus.protocol_err_o), 32'd0);
        check("rst_rf_we", 32'(bus.rf_write_enable_o), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_fill_ready", 32'(bus.fill_ready_o), 32'd1);

        // Single fill with writeback idle.
        drive(1'b0, 7'h0, 32'h0, 1'b1, 7'h05, 32'hA5A5A5A5);
        expect_wr(7'h05, 32'hA5A5A5A5);
        #3;
        check("t1_accept_cycle_we", 32'(bus.rf_write_enable_o), 32'(BYP));
        tick();
        drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0);
        #3;
        check("t1_next_cycle_we", 32'(bus.rf_write_enable_o), 32'(!BYP));
        tick();

        // Squash: fills 10,11,10 queued behind writebacks, then writeback to 10.
        drive(1'b1, 7'h40, 32'h40, 1'b1, 7'h10, 32'hAAAA0001); expect_wr(7'h40, 32'h40); tick();
        drive(1'b1, 7'h41, 32'h41, 1'b1, 7'h11, 32'hBBBB0002); expect_wr(7'h41, 32'h41); tick();
        drive(1'b1, 7'h42, 32'h42, 1'b1, 7'h10, 32'hCCCC0003); expect_wr(7'h42, 32'h42); tick();
        drive(1'b1, 7'h10, 32'h1, 1'b0, 7'h0, 32'h0);          expect_wr(7'h10, 32'h1);  tick();
        drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0);
        #3;
        check("t3_squashed_head_we", 32'(bus.rf_write_enable_o), 32'd0);
        tick();
        expect_wr(7'h11, 32'hBBBB0002);
        #3;
        check("t3_live_fill_we", 32'(bus.rf_write_enable_o), 32'd1);
        check("t3_live_fill_reg", 32'(bus.rf_write_reg_o), 32'h11);
        tick();
        #3;
        check("t3_second_squash_we", 32'(bus.rf_write_enable_o), 32'd0);
        tick();
        #3;
        check("t3_reg10_final", shadow[7'h10], 32'h1);
        check("t3_fill_ready", 32'(bus.fill_ready_o), 32'd1);
        tick();

        // Back-pressure: five fills against a saturated writeback stream.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 7'(7'h50 + k), 32'h5000 + 32'(k), 1'b1, 7'(7'h60 + k), 32'h6000 + 32'(k));
            expect_wr(7'(7'h50 + k), 32'h5000 + 32'(k));
            #3;
            check($sformatf("t4_ready_k%0d", k), 32'(bus.fill_ready_o), (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        drive(1'b0, 7'h0, 32'h0, 1'b1, 7'h64, 32'h6004);
        expect_wr(7'h60, 32'h6000);
        #3;
        check("t4_full_pop_ready", 32'(bus.fill_ready_o), 32'd0);
        check("t4_full_pop_we", 32'(bus.rf_write_enable_o), 32'd1);
        tick();
        expect_wr(7'h61, 32'h6001);
        #3;
        check("t4_ready_reraised", 32'(bus.fill_ready_o), 32'd1);
        tick();
        drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0);
        expect_wr(7'h62, 32'h6002);
        expect_wr(7'h63, 32'h6003);
        expect_wr(7'h64, 32'h6004);
        repeat (5) tick();
        check("t4_drained_ready", 32'(bus.fill_ready_o), 32'd1);

        // Starvation with writeback held through the forced stall (also a protocol error).
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 7'h20, 32'h2000 + 32'(i), (i == 0), 7'h30, 32'hBEEF);
            if (i == 9) expect_wr(7'h30, 32'hBEEF);
            else        expect_wr(7'h20, 32'h2000 + 32'(i));
            #3;
            if (i == 8 || i == 9 || i == 10)
                check($sformatf("t2_stall_c%0d", i), 32'(bus.stall_o), (i == 9) ? 32'd1 : 32'd0);
            if (i == 9)
                check("t5_err_before", 32'(bus.protocol_err_o), 32'd0);
            if (i == 10 || i == 19)
                check($sformatf("t5_err_c%0d", i), 32'(bus.protocol_err_o), 32'd1);
            tick();
        end
        drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0);
        tick();

        // Reset with three fills queued.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 7'(7'h70 + k), 32'h7000 + 32'(k), 1'b1, 7'(7'h78 + k), 32'h7800 + 32'(k));
            expect_wr(7'(7'h70 + k), 32'h7000 + 32'(k));
            tick();
        end
        drive(1'b1, 7'h7A, 32'hDEAD, 1'b0, 7'h0, 32'h0);
        reset = 1'b1;
        #3;
        check("t6_rst_ready", 32'(bus.fill_ready_o), 32'd0);
        check("t6_rst_we", 32'(bus.rf_write_enable_o), 32'd0);
        tick();
        drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0);
        tick();
        reset = 1'b0;
        #3;
        check("t6_err_cleared", 32'(bus.protocol_err_o), 32'd0);
        check("t6_release_we", 32'(bus.rf_write_enable_o), 32'd0);
        tick();
        check("t6_ready_after", 32'(bus.fill_ready_o), 32'd1);
        repeat (5) tick();

        check("outstanding_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
